ifetch_seq: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the execute unit of the single-issue MIPS core.
- Holds the PC and issues word reads to instruction memory over a req/ready handshake that tolerates wait states.
- Presents the fetched Instruction and PC_plus_4 to decode/execute.
- Selects the next PC from the execute unit's Zero and branch-target word address (Addr_Result), jump fields, or Jr register data, when control signals advance.

---
 rtl/ifetch_seq_if.sv | 10 +
 rtl/ifetch_seq.sv | 106 ++++++++++
 tb/tb_ifetch_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_seq_if.sv
// Instruction-memory read channel: req/addr from the fetch stage, ready/rdata back from memory.
interface ifetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/ifetch_seq.sv
// Instruction-fetch stage: holds the PC, reads one word per instruction over a wait-state
// tolerant handshake, and picks the next PC from jr / j / jal / branch controls on advance.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          rst_n,
    ifetch_seq_if.master  imem,
    output logic [31:0]   Instruction,
    output logic          inst_valid,
    output logic [31:0]   PC_plus_4,
    output logic [31:0]   pc_out,
    input  logic          advance,
    input  logic          Branch,
    input  logic          nBranch,
    input  logic          Jmp,
    input  logic          Jal,
    input  logic          Jr,
    input  logic          Zero,
    input  logic [31:0]   Addr_Result,
    input  logic [31:0]   Read_data_1,
    output logic [31:0]   link_addr,
    output logic          addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        fetch_done;
    logic        commit;
    logic        taken;
    logic [31:0] next_pc;
    logic        unused_addr_hi;

    // Addr_Result is a word address; its top two bits fall off when converted to bytes.
    assign unused_addr_hi = ^Addr_Result[31:30];

    assign PC_plus_4      = pc_out + 32'd4;
    assign imem.imem_addr = pc_out;
    // Decoded from the registered state so an async reset drops the request at once.
    assign imem.imem_req  = (state_q == FETCH);

    assign fetch_done = (state_q == FETCH) && imem.imem_ready;
    assign commit     = (state_q == HOLD) && advance;
    assign taken      = (Branch && Zero) || (nBranch && !Zero);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem.imem_ready) state_d = HOLD;
            HOLD:    if (advance) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        next_pc = PC_plus_4;
        if (Jr) begin
            next_pc = {Read_data_1[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            next_pc = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
        end else if (taken) begin
            next_pc = {Addr_Result[29:0], 2'b00};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_out      <= RESET_PC;
            Instruction <= 32'd0;
            inst_valid  <= 1'b0;
            link_addr   <= 32'd0;
            addr_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            addr_err <= commit && Jr && (Read_data_1[1:0] != 2'b00);
            if (fetch_done) begin
                Instruction <= imem.imem_rdata;
                inst_valid  <= 1'b1;
            end
            if (commit) begin
                pc_out     <= next_pc;
                inst_valid <= 1'b0;
                if (Jal) begin
                    link_addr <= PC_plus_4;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: directed scenarios plus randomized control flow
// compared against a PC/link model computed from the fetch rules with plain arithmetic.
module tb_ifetch_seq;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        advance, Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_Result, Read_data_1;
    logic [31:0] Instruction, PC_plus_4, pc_out, link_addr;
    logic        inst_valid, addr_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    ifetch_seq_if bus ();

    ifetch_seq #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .imem        (bus),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .PC_plus_4   (PC_plus_4),
        .pc_out      (pc_out),
        .advance     (advance),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_Result (Addr_Result),
        .Read_data_1 (Read_data_1),
        .link_addr   (link_addr),
        .addr_err    (addr_err)
    );

    typedef struct {
        logic        branch, nbranch, jmp, jal, jr, zero;
        logic [31:0] addr_result, rd1;
    } ctrl_t;

    typedef struct {
        logic [31:0] f_addr;
        bit          f_stable;
        logic        v_before;
        logic [31:0] instr;
        logic        v_hold;
        logic [31:0] pc4;
        logic [31:0] next_addr;
        logic        v_after;
        logic        err;
        logic [31:0] link;
    } obs_t;

    typedef struct {
        logic [31:0] f_addr, pc4, next_addr, link;
        logic        err;
    } exp_t;

    // Reference model state: architectural PC and return-address register.
    logic [31:0] m_pc;
    logic [31:0] m_link;

    function automatic ctrl_t no_ctrl();
        ctrl_t c;
        c = '{branch: 1'b0, nbranch: 1'b0, jmp: 1'b0, jal: 1'b0, jr: 1'b0, zero: 1'b0,
              addr_result: 32'd0, rd1: 32'd0};
        return c;
    endfunction

    task automatic model_instr(input logic [31:0] data, input ctrl_t c, output exp_t e);
        logic [31:0] p4;
        p4       = m_pc + 32'd4;
        e.f_addr = m_pc;
        e.pc4    = p4;
        if (c.jr)
            e.next_addr = c.rd1 & ~32'd3;
        else if (c.jmp || c.jal)
            e.next_addr = (p4 & 32'hF000_0000) | ((data & 32'h03FF_FFFF) * 4);
        else if ((c.branch && c.zero) || (c.nbranch && !c.zero))
            e.next_addr = c.addr_result * 4;
        else
            e.next_addr = p4;
        e.err = c.jr && ((c.rd1 % 4) != 0);
        if (c.jal) m_link = p4;
        e.link = m_link;
        m_pc   = e.next_addr;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ctrl(input ctrl_t c, input logic adv);
        Branch      = c.branch;
        nBranch     = c.nbranch;
        Jmp         = c.jmp;
        Jal         = c.jal;
        Jr          = c.jr;
        Zero        = c.zero;
        Addr_Result = c.addr_result;
        Read_data_1 = c.rd1;
        advance     = adv;
    endtask

    // One instruction: fetch with 'waits' wait states (advance/jal/jr asserted meanwhile,
    // which FETCH must ignore), then one HOLD cycle committing with controls c.
    task automatic run_instr(input logic [31:0] data, input int waits, input ctrl_t c, output obs_t o);
        ctrl_t noise;
        int n;
        o = '{f_addr: 'x, f_stable: 1'b0, v_before: 'x, instr: 'x, v_hold: 'x, pc4: 'x,
              next_addr: 'x, v_after: 'x, err: 'x, link: 'x};
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (bus.imem_req !== 1'b1) return;
        o.f_addr   = bus.imem_addr;
        o.f_stable = 1'b1;
        noise      = no_ctrl();
        noise.jal  = 1'b1;
        noise.jr   = 1'b1;
        noise.rd1  = 32'h0000_0003;
        for (int i = 0; i < waits; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            drive_ctrl(noise, 1'b1);
            step();
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== o.f_addr) o.f_stable = 1'b0;
        end
        drive_ctrl(no_ctrl(), 1'b0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = data;
        o.v_before     = inst_valid;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
        o.instr  = Instruction;
        o.v_hold = inst_valid;
        o.pc4    = PC_plus_4;
        drive_ctrl(c, 1'b1);
        step();
        drive_ctrl(no_ctrl(), 1'b0);
        o.next_addr = bus.imem_addr;
        o.v_after   = inst_valid;
        o.err       = addr_err;
        o.link      = link_addr;
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        drive_ctrl(no_ctrl(), 1'b0);
        repeat (2) @(posedge clock);
        #1;
        tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
        tests_run++; if (PC_plus_4 !== 32'h4) begin tests_failed++; $display("FAIL reset_pc4: got %h want %h", PC_plus_4, 32'h4); end
        tests_run++; if (Instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", Instruction); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        tests_run++; if (link_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_link: got %h want 0", link_addr); end
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", addr_err); end
        rst_n = 1'b1;
        step();
        tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL stale_ready: inst_valid got %b want 0", inst_valid); end
        bus.imem_ready = 1'b0;
        m_pc   = 32'h0;
        m_link = 32'h0;
    endtask

    task automatic test_sequential();
        obs_t o;
        exp_t e;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            model_instr(d, no_ctrl(), e);
            run_instr(d, 0, no_ctrl(), o);
            tests_run++; if (o.f_addr !== e.f_addr) begin tests_failed++; $display("FAIL seq_addr[%0d]: got %h want %h", i, o.f_addr, e.f_addr); end
            tests_run++; if (o.instr !== d) begin tests_failed++; $display("FAIL seq_instr[%0d]: got %h want %h", i, o.instr, d); end
            tests_run++; if (o.v_before !== 1'b0 || o.v_hold !== 1'b1 || o.v_after !== 1'b0)
                begin tests_failed++; $display("FAIL seq_valid[%0d]: got %b%b%b want 010", i, o.v_before, o.v_hold, o.v_after); end
            tests_run++; if (o.next_addr !== e.next_addr) begin tests_failed++; $display("FAIL seq_next[%0d]: got %h want %h", i, o.next_addr, e.next_addr); end
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        exp_t e;
        ctrl_t c;
        logic [31:0] d;
        c = no_ctrl();
        c.jmp = 1'b1;
        model_instr(32'h0800_0008, c, e);
        run_instr(32'h0800_0008, 0, c, o);
        tests_run++; if (o.next_addr !== 32'h20) begin tests_failed++; $display("FAIL jmp_to_20: got %h want %h", o.next_addr, 32'h20); end
        d = $urandom;
        model_instr(d, no_ctrl(), e);
        run_instr(d, 3, no_ctrl(), o);
        tests_run++; if (o.f_addr !== 32'h20) begin tests_failed++; $display("FAIL wait_addr: got %h want %h", o.f_addr, 32'h20); end
        tests_run++; if (o.f_stable !== 1'b1) begin tests_failed++; $display("FAIL wait_stable: got %b want 1", o.f_stable); end
        tests_run++; if (o.v_before !== 1'b0 || o.v_hold !== 1'b1) begin tests_failed++; $display("FAIL wait_valid: got %b%b want 01", o.v_before, o.v_hold); end
        tests_run++; if (o.instr !== d) begin tests_failed++; $display("FAIL wait_instr: got %h want %h", o.instr, d); end
        tests_run++; if (o.err !== 1'b0 || o.link !== e.link) begin tests_failed++; $display("FAIL fetch_ignores_ctrl: err %b link %h want 0 %h", o.err, o.link, e.link); end
    endtask

    task automatic test_branch();
        obs_t o;
        exp_t e;
        ctrl_t cj, cb;
        logic [31:0] d;
        cj = no_ctrl();
        cj.jmp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_instr(32'h0800_000C, cj, e);
            run_instr(32'h0800_000C, 0, cj, o);
            tests_run++; if (o.next_addr !== 32'h30) begin tests_failed++; $display("FAIL jmp_to_30[%0d]: got %h want %h", k, o.next_addr, 32'h30); end
            cb = no_ctrl();
            cb.addr_result = 32'h10;
            cb.branch  = (k != 2);
            cb.nbranch = (k == 2);
            cb.zero    = (k == 0);
            d = $urandom & 32'h03FF_FFFF;
            model_instr(d, cb, e);
            run_instr(d, 0, cb, o);
            tests_run++; if (o.pc4 !== 32'h34) begin tests_failed++; $display("FAIL br_pc4[%0d]: got %h want %h", k, o.pc4, 32'h34); end
            tests_run++; if (o.next_addr !== e.next_addr) begin tests_failed++; $display("FAIL br_next[%0d]: got %h want %h", k, o.next_addr, e.next_addr); end
        end
    endtask

    task automatic test_jal_jr();
        obs_t o;
        exp_t e;
        ctrl_t c;
        c = no_ctrl();
        c.jmp = 1'b1;
        model_instr(32'h0810_0000, c, e);
        run_instr(32'h0810_0000, 0, c, o);
        tests_run++; if (o.next_addr !== 32'h0040_0000) begin tests_failed++; $display("FAIL jmp_far: got %h want %h", o.next_addr, 32'h0040_0000); end
        c = no_ctrl();
        c.jal = 1'b1;
        model_instr(32'h0C00_0100, c, e);
        run_instr(32'h0C00_0100, 1, c, o);
        tests_run++; if (o.next_addr !== 32'h0000_0400) begin tests_failed++; $display("FAIL jal_next: got %h want %h", o.next_addr, 32'h400); end
        tests_run++; if (o.link !== 32'h0040_0004) begin tests_failed++; $display("FAIL jal_link: got %h want %h", o.link, 32'h0040_0004); end
        tests_run++; if (o.err !== 1'b0) begin tests_failed++; $display("FAIL jal_err: got %b want 0", o.err); end
        c = no_ctrl();
        c.jr  = 1'b1;
        c.rd1 = 32'h0000_1002;
        model_instr(32'h0, c, e);
        run_instr(32'h0, 0, c, o);
        tests_run++; if (o.next_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL jr_next: got %h want %h", o.next_addr, 32'h1000); end
        tests_run++; if (o.err !== 1'b1) begin tests_failed++; $display("FAIL jr_err_pulse: got %b want 1", o.err); end
        tests_run++; if (o.link !== 32'h0040_0004) begin tests_failed++; $display("FAIL jr_link_held: got %h want %h", o.link, 32'h0040_0004); end
        step();
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL jr_err_single: got %b want 0", addr_err); end
    endtask

    task automatic test_priority();
        obs_t o;
        exp_t e;
        ctrl_t c;
        logic [31:0] d;
        c = no_ctrl();
        c.jr = 1'b1;
        c.branch = 1'b1;
        c.zero = 1'b1;
        c.jmp = 1'b1;
        c.addr_result = 32'h0000_0123;
        c.rd1 = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
        d = $urandom;
        model_instr(d, c, e);
        run_instr(d, 0, c, o);
        tests_run++; if (o.next_addr !== e.next_addr) begin tests_failed++; $display("FAIL prio_jr: got %h want %h", o.next_addr, e.next_addr); end
        c = no_ctrl();
        c.jr  = 1'b1;
        c.rd1 = 32'hFFFF_FFFC;
        model_instr(d, c, e);
        run_instr(d, 0, c, o);
        tests_run++; if (o.next_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL jr_top: got %h want %h", o.next_addr, 32'hFFFF_FFFC); end
    endtask

    task automatic test_wrap();
        obs_t o;
        exp_t e;
        logic [31:0] d;
        d = $urandom;
        model_instr(d, no_ctrl(), e);
        run_instr(d, 0, no_ctrl(), o);
        tests_run++; if (o.pc4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4: got %h want 0", o.pc4); end
        tests_run++; if (o.next_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next: got %h want 0", o.next_addr); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        ctrl_t c;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            c.branch      = ($urandom_range(0, 3) == 0);
            c.nbranch     = ($urandom_range(0, 3) == 0);
            c.jmp         = ($urandom_range(0, 5) == 0);
            c.jal         = ($urandom_range(0, 5) == 0);
            c.jr          = ($urandom_range(0, 5) == 0);
            c.zero        = $urandom_range(0, 1);
            c.addr_result = $urandom;
            c.rd1         = $urandom;
            d             = $urandom;
            model_instr(d, c, e);
            run_instr(d, $urandom_range(0, 2), c, o);
            tests_run++; if (o.f_addr !== e.f_addr) begin tests_failed++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, o.f_addr, e.f_addr); end
            tests_run++; if (o.instr !== d) begin tests_failed++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, o.instr, d); end
            tests_run++; if (o.next_addr !== e.next_addr) begin tests_failed++; $display("FAIL rnd_next[%0d]: got %h want %h", i, o.next_addr, e.next_addr); end
            tests_run++; if (o.link !== e.link) begin tests_failed++; $display("FAIL rnd_link[%0d]: got %h want %h", i, o.link, e.link); end
            tests_run++; if (o.err !== e.err) begin tests_failed++; $display("FAIL rnd_err[%0d]: got %b want %b", i, o.err, e.err); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        obs_t o;
        exp_t e;
        logic [31:0] d;
        bus.imem_ready = 1'b0;
        step();
        rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        #1;
        tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_req: got %b want 0", bus.imem_req); end
        step();
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", inst_valid); end
        rst_n = 1'b1;
        step();
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale: got %b want 0", inst_valid); end
        tests_run++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL midrst_restart: addr %h req %b want 0 1", bus.imem_addr, bus.imem_req); end
        bus.imem_ready = 1'b0;
        m_pc   = 32'h0;
        m_link = 32'h0;
        d = $urandom;
        model_instr(d, no_ctrl(), e);
        run_instr(d, 0, no_ctrl(), o);
        tests_run++; if (o.f_addr !== 32'h0 || o.instr !== d) begin tests_failed++; $display("FAIL midrst_fetch: addr %h instr %h want 0 %h", o.f_addr, o.instr, d); end
        tests_run++; if (o.link !== 32'h0) begin tests_failed++; $display("FAIL midrst_link: got %h want 0", o.link); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jal_jr();
        test_priority();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
